// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
// Optional packet locking is built when MUX_ARB_PKT_LOCK_EN is defined.
package mux_arb_pkg;

  localparam int WIDTH_DEF     = 64;
  localparam int SEL_WIDTH_DEF = 2;
  localparam int NUM_REQ       = 4;

  typedef logic [SEL_WIDTH_DEF-1:0] sel_t;

  // ARB_LOCKED is only reachable when packet locking is built in.
  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Two-bit index, so the increment wraps 3 -> 0 on its own.
  function automatic sel_t sel_inc(input sel_t s);
    return sel_t'(s + sel_t'(1));
  endfunction

endpackage

// File: rtl/mux_arb_4to1_64bit_if.sv
// Bus bundle for mux_arb_4to1_64bit: four requester payloads plus the output beat.
// in_last/out_last exist only when MUX_ARB_PKT_LOCK_EN is defined.
interface mux_arb_4to1_64bit_if
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SEL_WIDTH = SEL_WIDTH_DEF
) ();

  // Handshake: a beat moves on a rising edge when valid and ready are both high.
  // in_ready may depend combinationally on in_valid and out_ready.
  logic [WIDTH-1:0]     data0;
  logic [WIDTH-1:0]     data1;
  logic [WIDTH-1:0]     data2;
  logic [WIDTH-1:0]     data3;
  logic [3:0]           in_valid;
  logic [3:0]           in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_WIDTH-1:0] out_sel;
`ifdef MUX_ARB_PKT_LOCK_EN
  logic [3:0]           in_last;
  logic                 out_last;
`endif
  sel_t                 dbg_ptr;
  arb_state_t           dbg_state;

  modport slave (
    input  data0, data1, data2, data3, in_valid, out_ready,
`ifdef MUX_ARB_PKT_LOCK_EN
    input  in_last,
    output out_last,
`endif
    output in_ready, out_valid, out_data, out_sel, dbg_ptr, dbg_state
  );

  modport master (
    output data0, data1, data2, data3, in_valid, out_ready,
`ifdef MUX_ARB_PKT_LOCK_EN
    output in_last,
    input  out_last,
`endif
    input  in_ready, out_valid, out_data, out_sel, dbg_ptr, dbg_state
  );

endinterface

// File: rtl/mux_arb_4to1_64bit_rr_pick4.sv
// Rotating-priority picker: first set req bit searching ptr, ptr+1, ... modulo 4.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [3:0] req,
  input  sel_t       ptr,
  output logic       gnt_valid,
  output sel_t       gnt_idx
);

  sel_t idx;

  // Walk from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    idx       = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = sel_t'(ptr + sel_t'(k));
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/mux_arb_4to1_64bit.sv
// 4:1 round-robin arbiter with a single registered output slot (1 beat/cycle).
// Define MUX_ARB_PKT_LOCK_EN to hold the grant until a beat with in_last set.
module mux_arb_4to1_64bit
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SEL_WIDTH = SEL_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_arb_4to1_64bit_if.slave   bus
);

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q,  out_data_d;
  logic [SEL_WIDTH-1:0] out_sel_q,   out_sel_d;
  sel_t                 ptr_q,       ptr_d;
  sel_t                 lock_idx_q,  lock_idx_d;
  arb_state_t           state_q,     state_d;
`ifdef MUX_ARB_PKT_LOCK_EN
  logic                 out_last_q,  out_last_d;
`endif

  logic [3:0]       req_eff;
  logic             gnt_valid;
  sel_t             gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             slot_free;
  logic             load;

  // While a packet is in flight only its owner may compete.
  always_comb begin
    req_eff = bus.in_valid;
    if (state_q == ARB_LOCKED) begin
      req_eff = bus.in_valid & (4'b0001 << lock_idx_q);
    end
  end

  rr_pick4 u_pick (
    .req       (req_eff),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    gnt_data = bus.data0;
    case (gnt_idx)
      2'd0:    gnt_data = bus.data0;
      2'd1:    gnt_data = bus.data1;
      2'd2:    gnt_data = bus.data2;
      default: gnt_data = bus.data3;
    endcase
  end

  assign slot_free = !out_valid_q || bus.out_ready;
  assign load      = slot_free && gnt_valid;

  // rst_n gates in_ready so nothing is accepted while reset is held.
  assign bus.in_ready = (rst_n && load) ? (4'b0001 << gnt_idx) : 4'b0000;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    lock_idx_d  = lock_idx_q;
    state_d     = state_q;
`ifdef MUX_ARB_PKT_LOCK_EN
    out_last_d  = out_last_q;
`endif
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_sel_d   = SEL_WIDTH'(gnt_idx);
`ifdef MUX_ARB_PKT_LOCK_EN
      out_last_d  = bus.in_last[gnt_idx];
      if (bus.in_last[gnt_idx]) begin
        ptr_d   = sel_inc(gnt_idx);
        state_d = ARB_OPEN;
      end else begin
        lock_idx_d = gnt_idx;
        state_d    = ARB_LOCKED;
      end
`else
      ptr_d   = sel_inc(gnt_idx);
      state_d = ARB_OPEN;
`endif
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
      lock_idx_q  <= '0;
      state_q     <= ARB_OPEN;
`ifdef MUX_ARB_PKT_LOCK_EN
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
      lock_idx_q  <= lock_idx_d;
      state_q     <= state_d;
`ifdef MUX_ARB_PKT_LOCK_EN
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.dbg_ptr   = ptr_q;
  assign bus.dbg_state = state_q;
`ifdef MUX_ARB_PKT_LOCK_EN
  assign bus.out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_mux_arb_4to1_64bit.sv
// Directed bench for mux_arb_4to1_64bit; the lock scenario runs when MUX_ARB_PKT_LOCK_EN is defined.
module tb_mux_arb_4to1_64bit;
  import mux_arb_pkg::*;

  localparam int W = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_arb_4to1_64bit_if #(.WIDTH(W), .SEL_WIDTH(2)) bus ();

  mux_arb_4to1_64bit #(.WIDTH(W), .SEL_WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] pay [4];
  int exp_seq [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data();
    bus.data0 = pay[0];
    bus.data1 = pay[1];
    bus.data2 = pay[2];
    bus.data3 = pay[3];
  endtask

  task automatic chk_beat(input string tag, input int sel, input logic [1:0] ptr);
    chk({tag, ".valid"}, W'(bus.out_valid), W'(1));
    chk({tag, ".sel"},   W'(bus.out_sel), W'(sel));
    chk({tag, ".data"},  bus.out_data, pay[sel]);
    chk({tag, ".ptr"},   W'(bus.dbg_ptr), W'(ptr));
  endtask

  initial begin
    pay[0] = 64'hA000_0000_0000_0000;
    pay[1] = 64'hA111_1111_1111_1111;
    pay[2] = 64'hA222_2222_2222_2222;
    pay[3] = 64'hA333_3333_3333_3333;
    drive_data();
    rst_n         = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
`ifdef MUX_ARB_PKT_LOCK_EN
    bus.in_last   = 4'b1111;
`endif
    #2;
    chk("rst.valid",    W'(bus.out_valid), W'(0));
    chk("rst.data",     bus.out_data, '0);
    chk("rst.sel",      W'(bus.out_sel), W'(0));
    chk("rst.ptr",      W'(bus.dbg_ptr), W'(0));
    chk("rst.in_ready", W'(bus.in_ready), W'(0));
    chk("rst.state",    W'(bus.dbg_state), W'(ARB_OPEN));

    // all four requesting, out_ready high: one beat per cycle in order 0,1,2,3,0
    #10;
    rst_n = 1'b1;
    #1;
    chk("rr.first_ready", W'(bus.in_ready), W'(4'b0001));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_beat($sformatf("rr%0d", i), exp_seq[i], 2'((exp_seq[i] + 1) % 4));
      chk($sformatf("rr%0d.in_ready", i), W'(bus.in_ready), W'(4'b0001 << ((exp_seq[i] + 1) % 4)));
    end

    // single requester 2
    pay[2] = 64'hDEAD_BEEF_0000_0002;
    drive_data();
    bus.in_valid = 4'b0100;
    #1;
    chk("one.in_ready", W'(bus.in_ready), W'(4'b0100));
    tick();
    chk_beat("one", 2, 2'd3);
    bus.in_valid = 4'b0000;
    #1;
    chk("drain.in_ready", W'(bus.in_ready), W'(0));
    tick();
    chk("drain.valid", W'(bus.out_valid), W'(0));
    chk("drain.ptr",   W'(bus.dbg_ptr), W'(3));

    // ptr=3 with requesters 3 and 0: grant 3, wrap, grant 0
    bus.in_valid = 4'b1001;
    #1;
    chk("wrap.in_ready3", W'(bus.in_ready), W'(4'b1000));
    tick();
    chk_beat("wrap3", 3, 2'd0);
    chk("wrap.in_ready0", W'(bus.in_ready), W'(4'b0001));
    tick();
    chk_beat("wrap0", 0, 2'd1);

    // stall five cycles: beat held, nothing accepted, ptr frozen
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    #1;
    chk("stall.in_ready0", W'(bus.in_ready), W'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_beat($sformatf("stall%0d", i), 0, 2'd1);
      chk($sformatf("stall%0d.in_ready", i), W'(bus.in_ready), W'(0));
    end
    bus.out_ready = 1'b1;
    #1;
    chk("unstall.in_ready", W'(bus.in_ready), W'(4'b0010));
    tick();
    chk_beat("unstall", 1, 2'd2);

    // reset mid-operation while a beat is held
    bus.in_valid = 4'b1110;
    rst_n = 1'b0;
    #1;
    chk("mrst.valid",    W'(bus.out_valid), W'(0));
    chk("mrst.data",     bus.out_data, '0);
    chk("mrst.sel",      W'(bus.out_sel), W'(0));
    chk("mrst.ptr",      W'(bus.dbg_ptr), W'(0));
    chk("mrst.in_ready", W'(bus.in_ready), W'(0));
    #2;
    rst_n = 1'b1;
    #1;
    chk("post.in_ready", W'(bus.in_ready), W'(4'b0010));
    tick();
    chk_beat("post", 1, 2'd2);

`ifdef MUX_ARB_PKT_LOCK_EN
    // move ptr to 1 with a single-beat packet from requester 0
    bus.in_valid = 4'b0011;
    bus.in_last  = 4'b1111;
    tick();
    chk_beat("lk.pre", 0, 2'd1);
    bus.in_last = 4'b0000;
    tick();
    chk_beat("lk.b1", 1, 2'd1);
    chk("lk.b1.last",  W'(bus.out_last), W'(0));
    chk("lk.b1.state", W'(bus.dbg_state), W'(ARB_LOCKED));
    chk("lk.b1.in_ready", W'(bus.in_ready), W'(4'b0010));
    tick();
    chk_beat("lk.b2", 1, 2'd1);
    chk("lk.b2.last", W'(bus.out_last), W'(0));
    bus.in_last = 4'b0010;
    tick();
    chk_beat("lk.b3", 1, 2'd2);
    chk("lk.b3.last",  W'(bus.out_last), W'(1));
    chk("lk.b3.state", W'(bus.dbg_state), W'(ARB_OPEN));
    bus.in_last = 4'b1111;
    tick();
    chk_beat("lk.after", 0, 2'd1);
    chk("lk.after.last", W'(bus.out_last), W'(1));
`endif

    bus.in_valid = 4'b0000;
    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
